// File: rtl/clk_div_ramp_ctrl.sv
// Ramp sequencer for a runtime-configurable integer clock divider: walks the
// divider from its current factor to a requested target in bounded, spaced steps.
module clk_div_ramp_ctrl #(
  parameter int DIV_VALUE_WIDTH   = 4,
  parameter int DEFAULT_DIV_VALUE = 0,
  parameter int DIV_STEP          = 1,
  parameter int HOLD_CYCLES       = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [DIV_VALUE_WIDTH-1:0] target_div_i,
  input  logic                       target_valid_i,
  output logic                       target_ready_o,
  output logic [DIV_VALUE_WIDTH-1:0] div_o,
  output logic                       div_valid_o,
  input  logic                       div_ready_i,
  output logic [DIV_VALUE_WIDTH-1:0] current_div_o,
  output logic                       busy_o
);

  localparam int W = DIV_VALUE_WIDTH;

  if (DIV_STEP < 1) begin : g_bad_step
    $error("clk_div_ramp_ctrl: DIV_STEP must be at least 1");
  end
  if ((DEFAULT_DIV_VALUE < 0) || (DEFAULT_DIV_VALUE >= (1 << W))) begin : g_bad_default
    $error("clk_div_ramp_ctrl: DEFAULT_DIV_VALUE does not fit in DIV_VALUE_WIDTH bits");
  end

  // A step larger than the value range behaves like "jump to target".
  localparam logic [W:0]   STEP_C  = (DIV_STEP >= (1 << W)) ? (W+1)'(1 << W) : (W+1)'(DIV_STEP);
  localparam logic [W-1:0] RST_DIV = (DEFAULT_DIV_VALUE == 0) ? W'(1) : W'(DEFAULT_DIV_VALUE);
  localparam int           HW      = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    cur_q, cur_d;
  logic [W-1:0]    div_q, div_d;
  logic            valid_q, valid_d;
  logic [W-1:0]    target_q, target_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [W-1:0]    target_norm;

  // One extra bit keeps the sum/difference from wrapping; the target clamps it.
  function automatic logic [W-1:0] next_step(input logic [W-1:0] cur, input logic [W-1:0] tgt);
    logic [W:0] c;
    logic [W:0] t;
    logic [W:0] s;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    if (t > c) begin
      s = c + STEP_C;
      if (s > t) s = t;
    end else if (c > STEP_C) begin
      s = c - STEP_C;
      if (s < t) s = t;
    end else begin
      s = t;
    end
    return s[W-1:0];
  endfunction

  assign target_norm = (target_div_i == '0) ? W'(1) : target_div_i;

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    div_d    = div_q;
    valid_d  = valid_q;
    target_d = target_q;
    hold_d   = hold_q;
    unique case (state_q)
      IDLE: begin
        if (target_valid_i) begin
          target_d = target_norm;
          if (target_norm != cur_q) begin
            div_d   = next_step(cur_q, target_norm);
            valid_d = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (div_ready_i) begin
          cur_d = div_q;
          if (div_q == target_q) begin
            valid_d = 1'b0;
            state_d = IDLE;
          end else if (HOLD_CYCLES == 0) begin
            div_d = next_step(div_q, target_q);
          end else begin
            valid_d = 1'b0;
            hold_d  = HOLD_LOAD;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        hold_d = hold_q - HW'(1);
        if (hold_q == HW'(1)) begin
          div_d   = next_step(cur_q, target_q);
          valid_d = 1'b1;
          state_d = REQ;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cur_q    <= RST_DIV;
      div_q    <= RST_DIV;
      valid_q  <= 1'b0;
      target_q <= RST_DIV;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      div_q    <= div_d;
      valid_q  <= valid_d;
      target_q <= target_d;
      hold_q   <= hold_d;
    end
  end

  assign target_ready_o = (state_q == IDLE);
  assign busy_o         = (state_q != IDLE);
  assign div_o          = div_q;
  assign div_valid_o    = valid_q;
  assign current_div_o  = cur_q;

endmodule

// File: tb/tb_clk_div_ramp_ctrl.sv
// Scoreboard bench: two instances (fine steps with settle gap, coarse steps
// back-to-back); expected step values and gaps are queued as each target is driven.
module tb_clk_div_ramp_ctrl;

  localparam int NDUT = 2;
  localparam int STEP_P [NDUT] = '{1, 4};
  localparam int HOLD_P [NDUT] = '{3, 0};

  logic       clk;
  logic       rst_n;
  logic [3:0] td       [NDUT];
  logic       tv       [NDUT];
  logic       tready_w [NDUT];
  logic [3:0] div_w    [NDUT];
  logic       valid_w  [NDUT];
  logic       rdy      [NDUT];
  logic [3:0] cur_w    [NDUT];
  logic       busy_w   [NDUT];

  typedef struct {
    int id;
    int div;
    int gap;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   low_cnt   [NDUT];
  int   model_cur [NDUT];
  int   tests_run    = 0;
  int   tests_failed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    clk_div_ramp_ctrl #(
      .DIV_VALUE_WIDTH  (4),
      .DEFAULT_DIV_VALUE(4),
      .DIV_STEP         (STEP_P[gi]),
      .HOLD_CYCLES      (HOLD_P[gi])
    ) u_dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .target_div_i  (td[gi]),
      .target_valid_i(tv[gi]),
      .target_ready_o(tready_w[gi]),
      .div_o         (div_w[gi]),
      .div_valid_o   (valid_w[gi]),
      .div_ready_i   (rdy[gi]),
      .current_div_o (cur_w[gi]),
      .busy_o        (busy_w[gi])
    );
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Handshake monitor: pops the scoreboard and counts low cycles between steps.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NDUT; k++) low_cnt[k] = 0;
    end else begin
      for (int k = 0; k < NDUT; k++) begin
        if (valid_w[k] && rdy[k]) begin
          $display("[TB] dut%0d step div=%0d gap=%0d", k, div_w[k], low_cnt[k]);
          if (exp_q.size() == 0) begin
            chk("unexpected_step", int'(div_w[k]), -1);
          end else begin
            e = exp_q.pop_front();
            chk("step_dut", k, e.id);
            chk("step_div", int'(div_w[k]), e.div);
            if (e.gap >= 0) chk("step_gap", low_cnt[k], e.gap);
          end
          low_cnt[k] = 0;
        end else if (!valid_w[k]) begin
          low_cnt[k]++;
        end
      end
    end
  end

  // Reference ramp: step toward the target by at most STEP, never past it.
  task automatic drive(input int k, input int tgt);
    int n;
    int c;
    bit first;
    n = (tgt == 0) ? 1 : tgt;
    c = model_cur[k];
    first = 1'b1;
    while (c != n) begin
      if (n > c) c = (n - c > STEP_P[k]) ? c + STEP_P[k] : n;
      else       c = (c - n > STEP_P[k]) ? c - STEP_P[k] : n;
      exp_q.push_back('{k, c, first ? -1 : HOLD_P[k]});
      first = 1'b0;
    end
    model_cur[k] = n;
    @(posedge clk); #1;
    tv[k] = 1'b1;
    td[k] = 4'(tgt);
    @(negedge clk);
    chk("target_ready_on_req", int'(tready_w[k]), 1);
    @(posedge clk); #1;
    tv[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!busy_w[k] && exp_q.size() == 0) break;
    end
    chk("idle_within_budget", int'(n < 300), 1);
    chk("current_div_final", int'(cur_w[k]), model_cur[k]);
    chk("target_ready_idle", int'(tready_w[k]), 1);
  endtask

  task automatic chk_reset(input int k);
    chk("rst_div_o", int'(div_w[k]), 4);
    chk("rst_current_div", int'(cur_w[k]), 4);
    chk("rst_div_valid", int'(valid_w[k]), 0);
    chk("rst_busy", int'(busy_w[k]), 0);
    chk("rst_target_ready", int'(tready_w[k]), 1);
  endtask

  initial begin
    int seen;
    int n;
    rst_n = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      td[k] = '0;
      tv[k] = 1'b0;
      rdy[k] = 1'b1;
      model_cur[k] = 4;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) chk_reset(k);

    // Target equal to current value: accepted, no downstream request.
    drive(0, 4);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (valid_w[0] || busy_w[0]) seen++;
    end
    chk("same_target_no_activity", seen, 0);

    drive(0, 7);
    wait_idle(0);
    drive(0, 0);
    wait_idle(0);

    // Stalled handshake: request must hold still.
    rdy[0] = 1'b0;
    drive(0, 3);
    for (n = 0; n < 20 && !valid_w[0]; n++) @(negedge clk);
    chk("stall_valid_seen", int'(valid_w[0]), 1);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (!valid_w[0] || div_w[0] != 4'd2 || tready_w[0]) seen++;
    end
    chk("stall_stable", seen, 0);
    @(posedge clk); #1 rdy[0] = 1'b1;
    wait_idle(0);

    // Coarse steps, back-to-back, saturating at the top of the range.
    drive(1, 15);
    wait_idle(1);
    drive(1, 2);
    wait_idle(1);

    // Asynchronous reset while settling between steps.
    drive(0, 9);
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (busy_w[0] && !valid_w[0] && cur_w[0] == 4'd4) break;
    end
    chk("reached_hold", int'(n < 50), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset(0);
    chk_reset(1);
    exp_q.delete();
    model_cur[0] = 4;
    model_cur[1] = 4;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drive(0, 6);
    wait_idle(0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
